// File: rtl/vga_adapter_mm_if.sv
// vga_adapter_mm_if: byte-wide video-RAM read port between the scan-out
// engine (master: drives the address) and the RAM arbiter (slave: returns data).
interface vga_adapter_mm_if;
   logic [15:0] vaddr;
   logic [7:0]  vdata;

   modport master (output vaddr, input vdata);
   modport slave  (input vaddr, output vdata);
endinterface

// File: rtl/vga_adapter_mm.sv
// vga_adapter_mm: multi-mode 640x400@70 Hz VGA scan-out engine.
// Beam counters, video-RAM fetch (4bpp / 1bpp / 2bpp / border-only),
// palette lookup and registered DAC/sync/irq outputs, 1 clock beam latency.
// Optional feature: define ADAPTER_PALETTE_EN for a writable 16x12 palette;
// without it the colour comes from the fixed RGBI map (pal_* ignored).
// WIN_W/WIN_H size the picture window (512x384 by default); the per-line
// byte stride of each mode follows from WIN_W.
module vga_adapter_mm #(
   parameter int          HZV   = 640,
   parameter int          HZF   = 16,
   parameter int          HZS   = 96,
   parameter int          HZB   = 48,
   parameter int          HZW   = 800,
   parameter int          VTV   = 400,
   parameter int          VTF   = 12,
   parameter int          VTS   = 2,
   parameter int          VTB   = 35,
   parameter int          VTW   = 449,
   parameter int          WIN_X = 64,
   parameter int          WIN_Y = 8,
   parameter int          WIN_W = 512,
   parameter int          WIN_H = 384,
   parameter logic [15:0] BASE  = 16'h4000
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [1:0]       mode,
   input  logic [11:0]      border,
   input  logic             pal_we,
   input  logic [3:0]       pal_addr,
   input  logic [11:0]      pal_data,
   vga_adapter_mm_if.master vram,
   output logic [3:0]       VGA_R,
   output logic [3:0]       VGA_G,
   output logic [3:0]       VGA_B,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             irq
);

   localparam int XW    = $clog2(HZW);
   localparam int YW    = $clog2(VTW);
   localparam int X_WIN = HZB + WIN_X;
   localparam int Y_WIN = VTB + WIN_Y;
   localparam int HS_ON = HZB + HZV + HZF;
   localparam int VS_ON = VTB + VTV + VTF;
   localparam logic [15:0] STRIDE_G4 = 16'(WIN_W / 4);
   localparam logic [15:0] STRIDE_G8 = 16'(WIN_W / 8);

   // Fixed RGBI map; also the default palette table.
   function automatic logic [11:0] rgbi(input logic [3:0] c);
      if (c == 4'd8) return 12'h888;
      return {c[3] & c[2], {3{c[2]}},
              c[3] & c[1], {3{c[1]}},
              c[3] & c[0], {3{c[0]}}};
   endfunction

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [1:0]    mr_q, mr_d;
   logic [15:0]   rowbase_q, rowbase_d;
   logic [15:0]   vaddr_q, vaddr_d;
   logic [7:0]    sh_q, sh_d;
   logic [11:0]   rgb_q, rgb_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          irq_q, irq_d;

   logic [3:0]    index;
   logic [11:0]   pal_rd;

   int   xi, yi, px, py, fpos, lpos, g_log, g_mask;
   logic visible, in_win, row_ok, line_end, frame_end, fetch_en, load_en;

   // Palette index at the head of the shifter, per mode (MSB-first).
   always_comb begin
      unique case (mr_q)
         2'd0:    index = sh_q[7:4];
         2'd1:    index = {4{sh_q[7]}};
         2'd2:    index = {2'b00, sh_q[7:6]};
         default: index = 4'd0;
      endcase
   end

`ifdef ADAPTER_PALETTE_EN
   logic [11:0] pal_q [16];

   // Writable palette, loaded with the RGBI table on reset.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         // NOTE: this small register file is reset on purpose so the default
         // table is present after reset; it is flops, not a RAM macro.
         for (int i = 0; i < 16; i++) pal_q[i] <= rgbi(4'(i));
      end else if (pal_we) begin
         pal_q[pal_addr] <= pal_data;
      end
   end

   assign pal_rd = pal_q[index];
`else
   logic pal_unused;
   assign pal_unused = ^{pal_we, pal_addr, pal_data};
   assign pal_rd     = rgbi(index);
`endif

   // Next-state logic: beam, mode, address generation, shifter and pixel.
   always_comb begin
      // NOTE: every output of this block is assigned on every path before
      // use, so no latch can be inferred.
      xi        = int'(x_q);
      yi        = int'(y_q);
      px        = xi - X_WIN;
      py        = yi - Y_WIN;
      fpos      = px + 3;
      lpos      = px + 1;
      g_log     = (mr_q == 2'd0) ? 2 : 3;
      g_mask    = (1 << g_log) - 1;
      line_end  = (xi == HZW - 1);
      frame_end = line_end && (yi == VTW - 1);
      visible   = (xi >= HZB) && (xi < HZB + HZV) && (yi >= VTB) && (yi < VTB + VTV);
      row_ok    = (py >= 0) && (py < WIN_H);
      in_win    = row_ok && (px >= 0) && (px < WIN_W);
      fetch_en  = (mr_q != 2'd3) && row_ok && (fpos >= 0) && (fpos < WIN_W)
                  && ((fpos & g_mask) == 0);
      load_en   = (mr_q != 2'd3) && row_ok && (lpos >= 0) && (lpos < WIN_W)
                  && ((lpos & g_mask) == 0);

      x_d = line_end ? '0 : x_q + 1'b1;
      y_d = y_q;
      if (line_end) y_d = (yi == VTW - 1) ? '0 : y_q + 1'b1;

      mr_d  = frame_end ? mode : mr_q;
      irq_d = frame_end;

      rowbase_d = rowbase_q;
      if (frame_end)
         rowbase_d = BASE;
      else if (line_end && row_ok && ((py & 1) == 1))
         rowbase_d = rowbase_q + ((g_log == 2) ? STRIDE_G4 : STRIDE_G8);

      vaddr_d = fetch_en ? rowbase_q + 16'(fpos >> g_log) : vaddr_q;

      sh_d = sh_q;
      if (load_en)
         sh_d = vram.vdata;
      else if (mr_q == 2'd1)
         sh_d = {sh_q[6:0], 1'b0};
      else if ((px & 1) == 1)
         sh_d = (mr_q == 2'd0) ? {sh_q[3:0], 4'h0} : {sh_q[5:0], 2'b00};

      if (!visible)
         rgb_d = 12'h000;
      else if (in_win && (mr_q != 2'd3))
         rgb_d = pal_rd;
      else
         rgb_d = border;

      hs_d = !((xi >= HS_ON) && (xi < HS_ON + HZS));
      vs_d = (yi >= VS_ON) && (yi < VS_ON + VTS);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLOCK) begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // register sees the pre-edge value of every other register.
      if (RESET) begin
         x_q       <= '0;
         y_q       <= '0;
         mr_q      <= 2'd0;
         rowbase_q <= BASE;
         vaddr_q   <= 16'h0000;
         sh_q      <= 8'h00;
         rgb_q     <= 12'h000;
         hs_q      <= 1'b1;
         vs_q      <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         mr_q      <= mr_d;
         rowbase_q <= rowbase_d;
         vaddr_q   <= vaddr_d;
         sh_q      <= sh_d;
         rgb_q     <= rgb_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         irq_q     <= irq_d;
      end
   end

   assign {VGA_R, VGA_G, VGA_B} = rgb_q;
   assign VGA_HS     = hs_q;
   assign VGA_VS     = vs_q;
   assign irq        = irq_q;
   assign vram.vaddr = vaddr_q;

endmodule

// File: tb/tb_vga_adapter_mm.sv
// tb_vga_adapter_mm: directed bench for vga_adapter_mm on a shrunk raster
// (98x27 clocks/lines, 64x12 window) so several frames fit in a short run.
// Window: X 14..77, Y 5..16. Visible: X 6..85, Y 3..22.
// HS low X 90..97; VS high Y 25..26. Strides: mode 0 = 16, modes 1/2 = 8.
module tb_vga_adapter_mm;
   localparam int HZV = 80, HZF = 4, HZS = 8, HZB = 6, HZW = 98;
   localparam int VTV = 20, VTF = 2, VTS = 2, VTB = 3, VTW = 27;
   localparam int WIN_X = 8, WIN_Y = 2, WIN_W = 64, WIN_H = 12;
   localparam int FRAME = HZW * VTW;
   localparam logic [11:0] BORDER = 12'h5A3;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic [11:0] border = BORDER;
   logic        pal_we = 1'b0;
   logic [3:0]  pal_addr = 4'd0;
   logic [11:0] pal_data = 12'h000;
   logic [3:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, irq;
   logic [11:0] rgb;

   logic [7:0]  mem [0:65535];
   int          bx = 0, by = 0;
   int          n_checks = 0, n_pass = 0;

   vga_adapter_mm_if vif ();

   vga_adapter_mm #(
      .HZV(HZV), .HZF(HZF), .HZS(HZS), .HZB(HZB), .HZW(HZW),
      .VTV(VTV), .VTF(VTF), .VTS(VTS), .VTB(VTB), .VTW(VTW),
      .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_W(WIN_W), .WIN_H(WIN_H),
      .BASE(16'h4000)
   ) dut (
      .CLOCK(CLOCK), .RESET(RESET), .mode(mode), .border(border),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .vram(vif),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .irq(irq)
   );

   assign rgb = {VGA_R, VGA_G, VGA_B};

   always #20 CLOCK = ~CLOCK;

   // Video RAM with one registered read stage.
   always @(posedge CLOCK) vif.vdata <= mem[vif.vaddr];

   // Reference beam position (what the DUT counters should hold this cycle).
   always @(posedge CLOCK) begin
      if (RESET) begin
         bx <= 0;
         by <= 0;
      end else if (bx == HZW - 1) begin
         bx <= 0;
         by <= (by == VTW - 1) ? 0 : by + 1;
      end else begin
         bx <= bx + 1;
      end
   end

   // Advance to the negedge where the reference beam is at (x,y); outputs
   // seen there describe beam position x-1 of the same line.
   task automatic wait_pos(input int x, input int y);
      int n = 0;
      do begin
         @(negedge CLOCK);
         n++;
      end while (!(bx == x && by == y) && n < 2 * FRAME);
      if (!(bx == x && by == y)) begin
         n_checks++;
         $display("FAIL wait_pos: beam (%0d,%0d) never reached", x, y);
      end
   endtask

   task automatic wait_irq(input string tag);
      int n = 0;
      do begin
         @(negedge CLOCK);
         n++;
      end while (irq !== 1'b1 && n < 2 * FRAME);
      n_checks++;
      if (irq !== 1'b1) $display("FAIL %s irq: got none within %0d clocks", tag, 2 * FRAME);
      else n_pass++;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge CLOCK);
      n_checks++;
      if (rgb !== 12'h000) $display("FAIL reset_rgb: got %h want 000", rgb); else n_pass++;
      n_checks++;
      if (VGA_HS !== 1'b1) $display("FAIL reset_hs: got %b want 1", VGA_HS); else n_pass++;
      n_checks++;
      if (VGA_VS !== 1'b0) $display("FAIL reset_vs: got %b want 0", VGA_VS); else n_pass++;
      n_checks++;
      if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
      n_checks++;
      if (vif.vaddr !== 16'h0000) $display("FAIL reset_vaddr: got %h want 0000", vif.vaddr);
      else n_pass++;
      RESET = 1'b0;
   endtask

   task automatic test_frame_timing();
      int hs_low = 0, vs_hi = 0, irqs = 0, irq_bad = 0;
      // Samples cover beam positions (0,0) through the end of frame 1.
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge CLOCK);
         if (VGA_HS === 1'b0) hs_low++;
         if (VGA_VS === 1'b1) vs_hi++;
         if (irq === 1'b1) begin
            irqs++;
            if (bx != 0 || by != 0) irq_bad++;
         end
      end
      n_checks++;  // 8 clocks x 27 lines x 2 frames
      if (hs_low != 432) $display("FAIL hs_low_count: got %0d want 432", hs_low); else n_pass++;
      n_checks++;  // 2 lines x 98 clocks x 2 frames
      if (vs_hi != 392) $display("FAIL vs_high_count: got %0d want 392", vs_hi); else n_pass++;
      n_checks++;
      if (irqs != 2) $display("FAIL irq_count: got %0d want 2", irqs); else n_pass++;
      n_checks++;
      if (irq_bad != 0) $display("FAIL irq_position: got %0d stray pulses want 0", irq_bad);
      else n_pass++;
      wait_pos(90, 10);
      n_checks++;
      if (VGA_HS !== 1'b1) $display("FAIL hs_x89: got %b want 1", VGA_HS); else n_pass++;
      wait_pos(91, 10);
      n_checks++;
      if (VGA_HS !== 1'b0) $display("FAIL hs_x90: got %b want 0", VGA_HS); else n_pass++;
      wait_pos(0, 11);
      n_checks++;
      if (VGA_HS !== 1'b0) $display("FAIL hs_x97: got %b want 0", VGA_HS); else n_pass++;
      wait_pos(1, 11);
      n_checks++;
      if (VGA_HS !== 1'b1) $display("FAIL hs_x0: got %b want 1", VGA_HS); else n_pass++;
      wait_pos(1, 24);
      n_checks++;
      if (VGA_VS !== 1'b0) $display("FAIL vs_y24: got %b want 0", VGA_VS); else n_pass++;
      wait_pos(0, 25);
      n_checks++;
      if (VGA_VS !== 1'b0) $display("FAIL vs_y24_end: got %b want 0", VGA_VS); else n_pass++;
      wait_pos(1, 25);
      n_checks++;
      if (VGA_VS !== 1'b1) $display("FAIL vs_y25: got %b want 1", VGA_VS); else n_pass++;
   endtask

   task automatic test_mode0();
      logic [11:0] exp_px [4] = '{12'hF00, 12'hF00, 12'h00F, 12'h00F};
      mem[16'h4000] = 8'hC9;  // index 12 then index 9
      wait_pos(6, 5);
      n_checks++;
      if (rgb !== 12'h000) $display("FAIL m0_blank: got %h want 000", rgb); else n_pass++;
      wait_pos(11, 5);
      n_checks++;  // last fetch of the previous frame: 0x4000 + 5*16 + 15
      if (vif.vaddr !== 16'h405F) $display("FAIL m0_vaddr_hold: got %h want 405F", vif.vaddr);
      else n_pass++;
      wait_pos(12, 5);
      n_checks++;
      if (vif.vaddr !== 16'h4000) $display("FAIL m0_vaddr_first: got %h want 4000", vif.vaddr);
      else n_pass++;
      wait_pos(14, 5);
      n_checks++;
      if (rgb !== BORDER) $display("FAIL m0_border: got %h want %h", rgb, BORDER); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         wait_pos(15 + i, 5);
         n_checks++;
         if (rgb !== exp_px[i]) $display("FAIL m0_px%0d: got %h want %h", i, rgb, exp_px[i]);
         else n_pass++;
         if (i == 1) begin
            n_checks++;
            if (vif.vaddr !== 16'h4001) $display("FAIL m0_vaddr_k1: got %h want 4001", vif.vaddr);
            else n_pass++;
         end
      end
      wait_pos(72, 5);
      n_checks++;
      if (vif.vaddr !== 16'h400F) $display("FAIL m0_vaddr_last: got %h want 400F", vif.vaddr);
      else n_pass++;
      wait_pos(15, 6);
      n_checks++;
      if (rgb !== 12'hF00) $display("FAIL m0_py1_px0: got %h want F00", rgb); else n_pass++;
      wait_pos(12, 7);
      n_checks++;
      if (vif.vaddr !== 16'h4010) $display("FAIL m0_stride: got %h want 4010", vif.vaddr);
      else n_pass++;
   endtask

   task automatic test_mode1();
      logic [11:0] exp_px [8] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000,
                                  12'h000, 12'hFFF, 12'h000, 12'hFFF};
      mode = 2'd1;
      wait_irq("m1");
      mem[16'h4008] = 8'hA5;  // source row 1
      for (int i = 0; i < 8; i++) begin
         wait_pos(15 + i, 7);
         n_checks++;
         if (rgb !== exp_px[i]) $display("FAIL m1_py2_px%0d: got %h want %h", i, rgb, exp_px[i]);
         else n_pass++;
      end
      wait_pos(68, 7);
      n_checks++;
      if (vif.vaddr !== 16'h400F) $display("FAIL m1_vaddr_last: got %h want 400F", vif.vaddr);
      else n_pass++;
      wait_pos(76, 7);
      n_checks++;
      if (vif.vaddr !== 16'h400F) $display("FAIL m1_no_extra_fetch: got %h want 400F", vif.vaddr);
      else n_pass++;
      wait_pos(20, 8);
      n_checks++;
      if (rgb !== 12'hFFF) $display("FAIL m1_py3_px5: got %h want FFF", rgb); else n_pass++;
   endtask

   task automatic test_mode_change();
      mode = 2'd0;
      wait_irq("mc_to0");
      mem[16'h4030] = 8'h1B;
      wait_pos(0, 10);
      mode = 2'd2;  // mid-frame request, must wait for frame start
      wait_pos(12, 11);
      n_checks++;  // still mode 0: 0x4000 + 3*16
      if (vif.vaddr !== 16'h4030) $display("FAIL mc_same_frame_vaddr: got %h want 4030", vif.vaddr);
      else n_pass++;
      wait_pos(15, 11);
      n_checks++;  // 4bpp view of 0x1B: index 1
      if (rgb !== 12'h007) $display("FAIL mc_same_frame_px: got %h want 007", rgb); else n_pass++;
      wait_irq("mc_to2");
      mem[16'h4008] = 8'h1B;
      wait_pos(12, 7);
      n_checks++;  // mode 2: 0x4000 + 1*8
      if (vif.vaddr !== 16'h4008) $display("FAIL m2_stride: got %h want 4008", vif.vaddr);
      else n_pass++;
      wait_pos(17, 7);
      n_checks++;
      if (rgb !== 12'h007) $display("FAIL m2_px2: got %h want 007", rgb); else n_pass++;
      wait_pos(19, 7);
      n_checks++;
      if (rgb !== 12'h070) $display("FAIL m2_px4: got %h want 070", rgb); else n_pass++;
      wait_pos(21, 7);
      n_checks++;
      if (rgb !== 12'h077) $display("FAIL m2_px6: got %h want 077", rgb); else n_pass++;
   endtask

   task automatic test_mode3();
      mode = 2'd3;
      wait_irq("m3");
      wait_pos(12, 5);
      n_checks++;  // last mode-2 fetch: 0x4000 + 5*8 + 7
      if (vif.vaddr !== 16'h402F) $display("FAIL m3_vaddr_hold: got %h want 402F", vif.vaddr);
      else n_pass++;
      wait_pos(15, 5);
      n_checks++;
      if (rgb !== BORDER) $display("FAIL m3_win_border: got %h want %h", rgb, BORDER); else n_pass++;
      wait_pos(72, 10);
      n_checks++;
      if (vif.vaddr !== 16'h402F) $display("FAIL m3_vaddr_hold2: got %h want 402F", vif.vaddr);
      else n_pass++;
   endtask

   task automatic test_palette();
      logic [11:0] exp_new;
`ifdef ADAPTER_PALETTE_EN
      exp_new = 12'h0F0;
`else
      exp_new = 12'h000;
`endif
      mode = 2'd0;
      wait_irq("pal");
      wait_pos(30, 7);
      pal_we = 1'b1; pal_addr = 4'd0; pal_data = 12'h0F0;
      wait_pos(31, 7);
      pal_we = 1'b0;
      n_checks++;
      if (rgb !== 12'h000) $display("FAIL pal_before: got %h want 000", rgb); else n_pass++;
      wait_pos(32, 7);
      n_checks++;
      if (rgb !== exp_new) $display("FAIL pal_after: got %h want %h", rgb, exp_new); else n_pass++;
      wait_pos(81, 7);
      n_checks++;
      if (rgb !== BORDER) $display("FAIL pal_border: got %h want %h", rgb, BORDER); else n_pass++;
      wait_pos(32, 8);
      n_checks++;
      if (rgb !== exp_new) $display("FAIL pal_next_line: got %h want %h", rgb, exp_new); else n_pass++;
      pal_we = 1'b1; pal_data = 12'h000;
      @(negedge CLOCK);
      pal_we = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int irqs = 0;
      wait_pos(50, 10);
      RESET = 1'b1;
      @(negedge CLOCK);
      n_checks++;
      if (rgb !== 12'h000) $display("FAIL mid_reset_rgb: got %h want 000", rgb); else n_pass++;
      n_checks++;
      if (VGA_HS !== 1'b1 || VGA_VS !== 1'b0)
         $display("FAIL mid_reset_sync: got hs=%b vs=%b want hs=1 vs=0", VGA_HS, VGA_VS);
      else n_pass++;
      n_checks++;
      if (vif.vaddr !== 16'h0000) $display("FAIL mid_reset_vaddr: got %h want 0000", vif.vaddr);
      else n_pass++;
      RESET = 1'b0;
      wait_pos(1, 0);
      n_checks++;
      if (irq !== 1'b0) $display("FAIL mid_reset_no_irq: got %b want 0", irq); else n_pass++;
      for (int i = 0; i < FRAME - 1; i++) begin
         @(negedge CLOCK);
         if (irq === 1'b1) irqs++;
      end
      n_checks++;
      if (irqs != 1) $display("FAIL mid_reset_irq_count: got %0d want 1", irqs); else n_pass++;
      n_checks++;
      if (irq !== 1'b1) $display("FAIL mid_reset_irq_at_frame: got %b want 1", irq); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      test_reset();
      test_frame_timing();
      test_mode0();
      test_mode1();
      test_mode_change();
      test_mode3();
      test_palette();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
